fc8_int_ctrl: RTL and testbench

Interrupt status/enable controller for the FC8 system, sitting on the MMU's SFR bus beside the SFR block. It is the hardware side of the INT_STATUS write-1-to-clear (W1C) protocol that CPU code reads and clears:
- it turns 8 synchronous event lines into sticky status bits;
- it masks them with an enable register;
- it drives a registered, active-low IRQ to the CPU.

---
 rtl/fc8_int_ctrl.sv | 75 +++++++
 tb/tb_fc8_int_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fc8_int_ctrl.sv
`default_nettype none
// ============================================================================
// fc8_int_ctrl : sticky interrupt status (W1C) / enable / soft-set for FC8 SFR bus
// Rev 1.0
// ============================================================================
module fc8_int_ctrl #(
  parameter logic [15:0] INT_STATUS_ADDR = 16'h0014,
  parameter logic [15:0] INT_ENABLE_ADDR = 16'h0015,
  parameter logic [15:0] INT_SET_ADDR    = 16'h0016
) (
  input  logic        master_clk,
  input  logic        master_rst_n,
  input  logic        sfr_cs,
  input  logic        sfr_wr_en,
  input  logic [15:0] sfr_addr,
  input  logic [7:0]  sfr_data_in,
  output logic [7:0]  sfr_data_out,
  output logic        sfr_hit,
  input  logic [7:0]  evt_in,
  output logic        cpu_irq_n
);

  logic [7:0] status;
  logic [7:0] enable;
  logic [7:0] evt_prev;

  logic       wr;
  logic       hit_status;
  logic       hit_enable;
  logic       hit_set;
  logic [7:0] rise;
  logic [7:0] clr;
  logic [7:0] set;
  logic [7:0] status_next;
  logic [7:0] enable_next;

  always_comb begin
    hit_status  = (sfr_addr == INT_STATUS_ADDR);
    hit_enable  = (sfr_addr == INT_ENABLE_ADDR);
    hit_set     = (sfr_addr == INT_SET_ADDR);
    wr          = sfr_cs & sfr_wr_en;
    rise        = evt_in & ~evt_prev;
    clr         = (wr && hit_status) ? sfr_data_in : 8'h00;
    set         = rise | ((wr && hit_set) ? sfr_data_in : 8'h00);
    // Set is applied after clear so a same-cycle event survives a W1C.
    status_next = (status & ~clr) | set;
    enable_next = (wr && hit_enable) ? sfr_data_in : enable;
  end

  always_ff @(posedge master_clk) begin
    if (!master_rst_n) begin
      status    <= 8'h00;
      enable    <= 8'h00;
      evt_prev  <= evt_in;
      cpu_irq_n <= 1'b1;
    end else begin
      status    <= status_next;
      enable    <= enable_next;
      evt_prev  <= evt_in;
      cpu_irq_n <= ~|(status_next & enable_next);
    end
  end

  assign sfr_hit = sfr_cs & (hit_status | hit_enable | hit_set);

  always_comb begin
    sfr_data_out = 8'h00;
    if (sfr_cs && !sfr_wr_en) begin
      if (hit_status)      sfr_data_out = status;
      else if (hit_enable) sfr_data_out = enable;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fc8_int_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fc8_int_ctrl : directed scenarios plus randomized traffic against a bit-level model
// Rev 1.0
// ============================================================================
module tb_fc8_int_ctrl;

  localparam logic [15:0] A_STAT = 16'h0014;
  localparam logic [15:0] A_EN   = 16'h0015;
  localparam logic [15:0] A_SET  = 16'h0016;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic        wr;
  logic [15:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        hit;
  logic [7:0]  evt;
  logic        irq_n;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  logic [7:0] m_status;
  logic [7:0] m_enable;
  logic [7:0] m_prev;
  logic       m_irq_n;

  fc8_int_ctrl dut (
    .master_clk   (clk),
    .master_rst_n (rst_n),
    .sfr_cs       (cs),
    .sfr_wr_en    (wr),
    .sfr_addr     (addr),
    .sfr_data_in  (din),
    .sfr_data_out (dout),
    .sfr_hit      (hit),
    .evt_in       (evt),
    .cpu_irq_n    (irq_n)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_read(input logic [15:0] a);
    if (a == A_STAT) return m_status;
    if (a == A_EN)   return m_enable;
    return 8'h00;
  endfunction

  function automatic logic model_hit(input logic c, input logic [15:0] a);
    return c && (a == A_STAT || a == A_EN || a == A_SET);
  endfunction

  task automatic drive(input logic r, input logic [7:0] e, input logic c, input logic w,
                       input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    rst_n = r; evt = e; cs = c; wr = w; addr = a; din = d;
    #1;
  endtask

  // Advance one edge and move the model per the register rules, bit by bit.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_status = 8'h00; m_enable = 8'h00; m_irq_n = 1'b1; m_prev = evt;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (cs && wr && addr == A_STAT && din[i]) m_status[i] = 1'b0;
        if ((evt[i] && !m_prev[i]) || (cs && wr && addr == A_SET && din[i])) m_status[i] = 1'b1;
      end
      if (cs && wr && addr == A_EN) m_enable = din;
      m_prev  = evt;
      m_irq_n = ((m_status & m_enable) == 8'h00);
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 8'h01, 1'b0, 1'b0, 16'h0, 8'h00); tick();
    drive(1'b1, 8'h01, 1'b1, 1'b0, A_STAT, 8'h00);
    vectors++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", dout); end
    vectors++; if (irq_n !== 1'b1) begin errors++; $display("FAIL reset_irq got %b want 1", irq_n); end
    tick();
    vectors++; if (dout !== 8'h00) begin errors++; $display("FAIL held_line_no_event got %h want 00", dout); end
    drive(1'b1, 8'h00, 1'b0, 1'b0, 16'h0, 8'h00); tick();
    drive(1'b1, 8'h01, 1'b0, 1'b0, 16'h0, 8'h00); tick();
    drive(1'b1, 8'h00, 1'b1, 1'b0, A_STAT, 8'h00);
    vectors++; if (dout !== 8'h01) begin errors++; $display("FAIL reraise_status got %h want 01", dout); end
    vectors++; if (irq_n !== 1'b1) begin errors++; $display("FAIL disabled_irq got %b want 1", irq_n); end
    drive(1'b1, 8'h00, 1'b1, 1'b1, A_STAT, 8'hFF); tick();
  endtask

  task automatic test_w1c();
    drive(1'b1, 8'h00, 1'b1, 1'b1, A_EN, 8'h03); tick();
    drive(1'b1, 8'h03, 1'b0, 1'b0, 16'h0, 8'h00); tick();
    vectors++; if (irq_n !== 1'b0) begin errors++; $display("FAIL pulse_irq got %b want 0", irq_n); end
    drive(1'b1, 8'h00, 1'b1, 1'b0, A_STAT, 8'h00);
    vectors++; if (dout !== 8'h03) begin errors++; $display("FAIL pulse_status got %h want 03", dout); end
    vectors++; if (hit !== 1'b1) begin errors++; $display("FAIL status_hit got %b want 1", hit); end
    tick();
    drive(1'b1, 8'h00, 1'b1, 1'b1, A_STAT, 8'h01); tick();
    drive(1'b1, 8'h00, 1'b1, 1'b0, A_STAT, 8'h00);
    vectors++; if (dout !== 8'h02) begin errors++; $display("FAIL w1c_bit0 got %h want 02", dout); end
    vectors++; if (irq_n !== 1'b0) begin errors++; $display("FAIL w1c_bit0_irq got %b want 0", irq_n); end
    tick();
    drive(1'b1, 8'h00, 1'b1, 1'b1, A_STAT, 8'h02); tick();
    drive(1'b1, 8'h00, 1'b1, 1'b0, A_STAT, 8'h00);
    vectors++; if (dout !== 8'h00) begin errors++; $display("FAIL w1c_bit1 got %h want 00", dout); end
    vectors++; if (irq_n !== 1'b1) begin errors++; $display("FAIL w1c_bit1_irq got %b want 1", irq_n); end
    drive(1'b1, 8'h00, 1'b1, 1'b0, A_EN, 8'h00);
    vectors++; if (dout !== 8'h03) begin errors++; $display("FAIL enable_read got %h want 03", dout); end
    tick();
  endtask

  task automatic test_same_cycle();
    drive(1'b1, 8'h04, 1'b1, 1'b1, A_STAT, 8'h04); tick();
    drive(1'b1, 8'h00, 1'b1, 1'b0, A_STAT, 8'h00);
    vectors++; if (dout !== 8'h04) begin errors++; $display("FAIL set_beats_clear got %h want 04", dout); end
    tick();
    drive(1'b1, 8'h00, 1'b1, 1'b1, A_STAT, 8'h04); tick();
  endtask

  task automatic test_soft_set();
    drive(1'b1, 8'h00, 1'b1, 1'b1, A_EN, 8'h80); tick();
    drive(1'b1, 8'h00, 1'b1, 1'b1, A_SET, 8'h80); tick();
    vectors++; if (irq_n !== 1'b0) begin errors++; $display("FAIL soft_set_irq got %b want 0", irq_n); end
    drive(1'b1, 8'h00, 1'b1, 1'b0, A_STAT, 8'h00);
    vectors++; if (dout !== 8'h80) begin errors++; $display("FAIL soft_set_status got %h want 80", dout); end
    drive(1'b1, 8'h00, 1'b1, 1'b0, A_SET, 8'h00);
    vectors++; if (dout !== 8'h00) begin errors++; $display("FAIL set_reads_zero got %h want 00", dout); end
    vectors++; if (hit !== 1'b1) begin errors++; $display("FAIL set_hit got %b want 1", hit); end
    // Disabling holds status but releases the IRQ.
    drive(1'b1, 8'h00, 1'b1, 1'b1, A_EN, 8'h00); tick();
    vectors++; if (irq_n !== 1'b1) begin errors++; $display("FAIL disable_irq got %b want 1", irq_n); end
    drive(1'b1, 8'h00, 1'b1, 1'b1, A_EN, 8'h80); tick();
    vectors++; if (irq_n !== 1'b0) begin errors++; $display("FAIL reenable_irq got %b want 0", irq_n); end
    drive(1'b1, 8'h00, 1'b1, 1'b1, A_STAT, 8'h80); tick();
    vectors++; if (irq_n !== 1'b1) begin errors++; $display("FAIL soft_clear_irq got %b want 1", irq_n); end
  endtask

  task automatic test_level_hold();
    drive(1'b1, 8'h00, 1'b1, 1'b1, A_EN, 8'h02); tick();
    for (int c = 0; c < 20; c++) begin
      if (c == 5) drive(1'b1, 8'h02, 1'b1, 1'b1, A_STAT, 8'h02);
      else        drive(1'b1, 8'h02, 1'b0, 1'b0, 16'h0, 8'h00);
      tick();
    end
    drive(1'b1, 8'h02, 1'b1, 1'b0, A_STAT, 8'h00);
    vectors++; if (dout !== 8'h00) begin errors++; $display("FAIL held_no_reassert got %h want 00", dout); end
    vectors++; if (irq_n !== 1'b1) begin errors++; $display("FAIL held_irq got %b want 1", irq_n); end
    tick();
    drive(1'b1, 8'h00, 1'b0, 1'b0, 16'h0, 8'h00); tick();
    drive(1'b1, 8'h02, 1'b0, 1'b0, 16'h0, 8'h00); tick();
    drive(1'b1, 8'h02, 1'b1, 1'b0, A_STAT, 8'h00);
    vectors++; if (dout !== 8'h02) begin errors++; $display("FAIL rerise_status got %h want 02", dout); end
    vectors++; if (irq_n !== 1'b0) begin errors++; $display("FAIL rerise_irq got %b want 0", irq_n); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'h00, 1'b1, 1'b1, A_EN, 8'hFF); tick();
    drive(1'b1, 8'h00, 1'b1, 1'b1, A_SET, 8'hFF); tick();
    vectors++; if (irq_n !== 1'b0) begin errors++; $display("FAIL pre_reset_irq got %b want 0", irq_n); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 8'h00); tick();
    drive(1'b1, 8'h00, 1'b1, 1'b0, A_STAT, 8'h00);
    vectors++; if (dout !== 8'h00) begin errors++; $display("FAIL mid_reset_status got %h want 00", dout); end
    vectors++; if (irq_n !== 1'b1) begin errors++; $display("FAIL mid_reset_irq got %b want 1", irq_n); end
    drive(1'b1, 8'h00, 1'b1, 1'b0, A_EN, 8'h00);
    vectors++; if (dout !== 8'h00) begin errors++; $display("FAIL mid_reset_enable got %h want 00", dout); end
    drive(1'b1, 8'h00, 1'b1, 1'b0, 16'h0017, 8'h00);
    vectors++; if (hit !== 1'b0) begin errors++; $display("FAIL unmapped_hit got %b want 0", hit); end
    vectors++; if (dout !== 8'h00) begin errors++; $display("FAIL unmapped_data got %h want 00", dout); end
    // Unselected and unmapped writes must be ignored.
    drive(1'b1, 8'h00, 1'b0, 1'b1, A_EN, 8'hFF); tick();
    drive(1'b1, 8'h00, 1'b1, 1'b1, 16'h0013, 8'hFF); tick();
    drive(1'b1, 8'h00, 1'b1, 1'b0, A_EN, 8'h00);
    vectors++; if (dout !== 8'h00) begin errors++; $display("FAIL ignored_write got %h want 00", dout); end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic        c, w, r;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0: a = A_STAT;
        1: a = A_EN;
        2: a = A_SET;
        3: a = 16'h0017;
        default: a = 16'($urandom);
      endcase
      c = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1) == 1;
      r = ($urandom_range(0, 60) != 0);
      drive(r, 8'($urandom) & 8'($urandom), c, w, a, 8'($urandom));
      vectors++;
      if (hit !== model_hit(c, a)) begin
        errors++; $display("FAIL rand_hit n=%0d addr=%h got %b want %b", n, a, hit, model_hit(c, a));
      end
      if (c && !w) begin
        vectors++;
        if (dout !== model_read(a)) begin
          errors++; $display("FAIL rand_read n=%0d addr=%h got %h want %h", n, a, dout, model_read(a));
        end
      end
      tick();
      vectors++;
      if (irq_n !== m_irq_n) begin
        errors++; $display("FAIL rand_irq n=%0d got %b want %b", n, irq_n, m_irq_n);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; evt = 8'h00; cs = 1'b0; wr = 1'b0; addr = 16'h0; din = 8'h00;
    m_status = 8'h00; m_enable = 8'h00; m_prev = 8'h00; m_irq_n = 1'b1;
    test_reset();
    test_w1c();
    test_same_cycle();
    test_soft_set();
    test_level_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
